// File: rtl/octave_step_fsm.sv
// Octave selector: synchronised up/down buttons with edge detect, auto-repeat
// and wrap or saturate range, driving a binary index and a one-hot select.
module octave_step_fsm #(
   parameter int NUM_OCT       = 3,
   parameter int RESET_OCT     = 0,
   parameter int WRAP          = 1,
   parameter int REPEAT_CYCLES = 1000,
   localparam int OCT_W        = (NUM_OCT < 2) ? 1 : $clog2(NUM_OCT)
) (
   input  logic               clk,
   input  logic               nrst,
   input  logic               oct_down,
   input  logic               oct_up,
   output logic [OCT_W-1:0]   oct_sel,
   output logic [NUM_OCT-1:0] oct_onehot,
   output logic               oct_changed,
   output logic               at_min,
   output logic               at_max
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HOLD_DN,
      ST_HOLD_UP,
      ST_BOTH
   } state_t;

   localparam int                 CNT_W      = (REPEAT_CYCLES > 0) ? $clog2(REPEAT_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0]   CNT_MAX    = CNT_W'(REPEAT_CYCLES);
   localparam logic [OCT_W-1:0]   SEL_RST    = OCT_W'(RESET_OCT);
   localparam logic [OCT_W-1:0]   SEL_TOP    = OCT_W'(NUM_OCT - 1);
   localparam logic [NUM_OCT-1:0] ONEHOT_ONE = NUM_OCT'(1);
   localparam logic [NUM_OCT-1:0] ONEHOT_RST = ONEHOT_ONE << RESET_OCT;

   logic dn_s1_q, dn_s1_d, dn_s2_q, dn_s2_d, dn_p_q, dn_p_d;
   logic up_s1_q, up_s1_d, up_s2_q, up_s2_d, up_p_q, up_p_d;
   logic dn_arm_q, dn_arm_d, up_arm_q, up_arm_d;
   logic vld1_q, vld1_d, vld2_q, vld2_d;
   logic edge_dn, edge_up;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               step_dn, step_up;

   logic [OCT_W-1:0]   oct_sel_q, oct_sel_d;
   logic [NUM_OCT-1:0] oct_onehot_q, oct_onehot_d;
   logic               oct_changed_q, oct_changed_d;
   logic               at_min_q, at_min_d;
   logic               at_max_q, at_max_d;

   // A button only arms once a genuine low level has passed the synchroniser
   // after reset, so a press held through reset never produces a step.
   always_comb begin
      dn_s1_d  = oct_down;
      dn_s2_d  = dn_s1_q;
      dn_p_d   = dn_s2_q;
      up_s1_d  = oct_up;
      up_s2_d  = up_s1_q;
      up_p_d   = up_s2_q;
      vld1_d   = 1'b1;
      vld2_d   = vld1_q;
      dn_arm_d = dn_arm_q | (vld2_q & ~dn_s2_q);
      up_arm_d = up_arm_q | (vld2_q & ~up_s2_q);
      edge_dn  = dn_s2_q & ~dn_p_q & dn_arm_q;
      edge_up  = up_s2_q & ~up_p_q & up_arm_q;
   end

   // state_q always classifies the current s2 levels, so it is built from s1.
   always_comb begin
      state_d = ST_IDLE;
      case ({dn_s1_q, up_s1_q})
         2'b10:   state_d = ST_HOLD_DN;
         2'b01:   state_d = ST_HOLD_UP;
         2'b11:   state_d = ST_BOTH;
         default: state_d = ST_IDLE;
      endcase

      cnt_d   = '0;
      step_dn = 1'b0;
      step_up = 1'b0;
      case (state_q)
         ST_HOLD_DN: begin
            if (edge_dn) begin
               step_dn = 1'b1;
            end else if (dn_arm_q && (REPEAT_CYCLES > 0)) begin
               if (cnt_q == CNT_MAX) step_dn = 1'b1;
               else                  cnt_d   = cnt_q + CNT_W'(1);
            end
         end
         ST_HOLD_UP: begin
            if (edge_up) begin
               step_up = 1'b1;
            end else if (up_arm_q && (REPEAT_CYCLES > 0)) begin
               if (cnt_q == CNT_MAX) step_up = 1'b1;
               else                  cnt_d   = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            cnt_d = '0;
         end
      endcase
   end

   always_comb begin
      oct_sel_d = oct_sel_q;
      if (int'(oct_sel_q) > NUM_OCT - 1) begin
         oct_sel_d = SEL_RST;
      end else if (step_dn) begin
         if (oct_sel_q == SEL_TOP) oct_sel_d = (WRAP != 0) ? '0 : oct_sel_q;
         else                      oct_sel_d = oct_sel_q + OCT_W'(1);
      end else if (step_up) begin
         if (oct_sel_q == '0) oct_sel_d = (WRAP != 0) ? SEL_TOP : oct_sel_q;
         else                 oct_sel_d = oct_sel_q - OCT_W'(1);
      end
      oct_changed_d = (oct_sel_d != oct_sel_q);
      oct_onehot_d  = ONEHOT_ONE << oct_sel_d;
      at_min_d      = (oct_sel_d == '0);
      at_max_d      = (oct_sel_d == SEL_TOP);
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         dn_s1_q       <= 1'b0;
         dn_s2_q       <= 1'b0;
         dn_p_q        <= 1'b0;
         up_s1_q       <= 1'b0;
         up_s2_q       <= 1'b0;
         up_p_q        <= 1'b0;
         dn_arm_q      <= 1'b0;
         up_arm_q      <= 1'b0;
         vld1_q        <= 1'b0;
         vld2_q        <= 1'b0;
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         oct_sel_q     <= SEL_RST;
         oct_onehot_q  <= ONEHOT_RST;
         oct_changed_q <= 1'b0;
         at_min_q      <= (RESET_OCT == 0);
         at_max_q      <= (RESET_OCT == NUM_OCT - 1);
      end else begin
         dn_s1_q       <= dn_s1_d;
         dn_s2_q       <= dn_s2_d;
         dn_p_q        <= dn_p_d;
         up_s1_q       <= up_s1_d;
         up_s2_q       <= up_s2_d;
         up_p_q        <= up_p_d;
         dn_arm_q      <= dn_arm_d;
         up_arm_q      <= up_arm_d;
         vld1_q        <= vld1_d;
         vld2_q        <= vld2_d;
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         oct_sel_q     <= oct_sel_d;
         oct_onehot_q  <= oct_onehot_d;
         oct_changed_q <= oct_changed_d;
         at_min_q      <= at_min_d;
         at_max_q      <= at_max_d;
      end
   end

   assign oct_sel     = oct_sel_q;
   assign oct_onehot  = oct_onehot_q;
   assign oct_changed = oct_changed_q;
   assign at_min      = at_min_q;
   assign at_max      = at_max_q;

endmodule

// File: tb/tb_octave_step_fsm.sv
// Drives four differently parameterised octave selectors with the same button
// stream and compares every output each cycle against a behavioural model.
module tb_octave_step_fsm;

   localparam int P_N   [4] = '{3, 4, 8, 5};
   localparam int P_RST [4] = '{0, 0, 0, 3};
   localparam int P_WRAP[4] = '{1, 0, 1, 0};
   localparam int P_REP [4] = '{0, 0, 10, 4};

   logic clk = 1'b0;
   logic nrst;
   logic oct_down;
   logic oct_up;

   logic [1:0] sel0; logic [2:0] oh0; logic ch0, mn0, mx0;
   logic [1:0] sel1; logic [3:0] oh1; logic ch1, mn1, mx1;
   logic [2:0] sel2; logic [7:0] oh2; logic ch2, mn2, mx2;
   logic [2:0] sel3; logic [4:0] oh3; logic ch3, mn3, mx3;

   int vecCount = 0;
   int errCount = 0;

   int mOct[4];
   bit mChg[4];
   int mAge[4];
   bit hq[2][3];
   bit hv[2][3];
   bit armed[2];

   always #5 clk = ~clk;

   octave_step_fsm #(.NUM_OCT(3), .RESET_OCT(0), .WRAP(1), .REPEAT_CYCLES(0)) u_dut0 (
      .clk(clk), .nrst(nrst), .oct_down(oct_down), .oct_up(oct_up),
      .oct_sel(sel0), .oct_onehot(oh0), .oct_changed(ch0), .at_min(mn0), .at_max(mx0));
   octave_step_fsm #(.NUM_OCT(4), .RESET_OCT(0), .WRAP(0), .REPEAT_CYCLES(0)) u_dut1 (
      .clk(clk), .nrst(nrst), .oct_down(oct_down), .oct_up(oct_up),
      .oct_sel(sel1), .oct_onehot(oh1), .oct_changed(ch1), .at_min(mn1), .at_max(mx1));
   octave_step_fsm #(.NUM_OCT(8), .RESET_OCT(0), .WRAP(1), .REPEAT_CYCLES(10)) u_dut2 (
      .clk(clk), .nrst(nrst), .oct_down(oct_down), .oct_up(oct_up),
      .oct_sel(sel2), .oct_onehot(oh2), .oct_changed(ch2), .at_min(mn2), .at_max(mx2));
   octave_step_fsm #(.NUM_OCT(5), .RESET_OCT(3), .WRAP(0), .REPEAT_CYCLES(4)) u_dut3 (
      .clk(clk), .nrst(nrst), .oct_down(oct_down), .oct_up(oct_up),
      .oct_sel(sel3), .oct_onehot(oh3), .oct_changed(ch3), .at_min(mn3), .at_max(mx3));

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vecCount++;
      if (got !== exp) begin
         errCount++;
         $display("[TB] FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   task automatic readDut(input int i, output logic [31:0] s, output logic [31:0] oh,
                          output logic [31:0] ch, output logic [31:0] mn, output logic [31:0] mx);
      case (i)
         0:       begin s = 32'(sel0); oh = 32'(oh0); ch = 32'(ch0); mn = 32'(mn0); mx = 32'(mx0); end
         1:       begin s = 32'(sel1); oh = 32'(oh1); ch = 32'(ch1); mn = 32'(mn1); mx = 32'(mx1); end
         2:       begin s = 32'(sel2); oh = 32'(oh2); ch = 32'(ch2); mn = 32'(mn2); mx = 32'(mx2); end
         default: begin s = 32'(sel3); oh = 32'(oh3); ch = 32'(ch3); mn = 32'(mn3); mx = 32'(mx3); end
      endcase
   endtask

   // Level seen by the step logic at an edge is the raw sample from two edges
   // earlier; a rise counts only if a post-reset low was seen before it.
   task automatic modelStep();
      bit lvl[2];
      bit rise[2];
      bit stepDn, stepUp;
      int n;
      if (!nrst) begin
         for (int b = 0; b < 2; b++) begin
            armed[b] = 0;
            for (int j = 0; j < 3; j++) begin hq[b][j] = 0; hv[b][j] = 0; end
         end
         for (int i = 0; i < 4; i++) begin mOct[i] = P_RST[i]; mChg[i] = 0; mAge[i] = 0; end
         return;
      end
      for (int b = 0; b < 2; b++) begin
         lvl[b]  = hq[b][1];
         rise[b] = hq[b][1] && !hq[b][2] && armed[b];
      end
      for (int i = 0; i < 4; i++) begin
         stepDn = 0;
         stepUp = 0;
         if (lvl[0] && !lvl[1] && armed[0]) begin
            if (rise[0]) begin stepDn = 1; mAge[i] = 0; end
            else begin
               mAge[i]++;
               if (P_REP[i] > 0 && mAge[i] == P_REP[i] + 1) begin stepDn = 1; mAge[i] = 0; end
            end
         end else if (lvl[1] && !lvl[0] && armed[1]) begin
            if (rise[1]) begin stepUp = 1; mAge[i] = 0; end
            else begin
               mAge[i]++;
               if (P_REP[i] > 0 && mAge[i] == P_REP[i] + 1) begin stepUp = 1; mAge[i] = 0; end
            end
         end else begin
            mAge[i] = 0;
         end
         n = mOct[i];
         if (stepDn) n = P_WRAP[i] ? (mOct[i] + 1) % P_N[i] : ((mOct[i] + 1 > P_N[i] - 1) ? P_N[i] - 1 : mOct[i] + 1);
         if (stepUp) n = P_WRAP[i] ? (mOct[i] + P_N[i] - 1) % P_N[i] : ((mOct[i] == 0) ? 0 : mOct[i] - 1);
         mChg[i] = (n != mOct[i]);
         mOct[i] = n;
      end
      for (int b = 0; b < 2; b++) begin
         if (hv[b][1] && !hq[b][1]) armed[b] = 1;
         hq[b][2] = hq[b][1]; hv[b][2] = hv[b][1];
         hq[b][1] = hq[b][0]; hv[b][1] = hv[b][0];
         hv[b][0] = 1;
      end
      hq[0][0] = oct_down;
      hq[1][0] = oct_up;
   endtask

   task automatic checkAll();
      logic [31:0] s, oh, ch, mn, mx;
      for (int i = 0; i < 4; i++) begin
         readDut(i, s, oh, ch, mn, mx);
         checkOutput($sformatf("d%0d.sel", i), s, 32'(mOct[i]));
         checkOutput($sformatf("d%0d.onehot", i), oh, 32'(1) << mOct[i]);
         checkOutput($sformatf("d%0d.changed", i), ch, 32'(mChg[i]));
         checkOutput($sformatf("d%0d.at_min", i), mn, 32'(mOct[i] == 0));
         checkOutput($sformatf("d%0d.at_max", i), mx, 32'(mOct[i] == P_N[i] - 1));
      end
   endtask

   task automatic tick();
      @(posedge clk);
      modelStep();
      @(negedge clk);
      checkAll();
   endtask

   task automatic applyStimulus(input logic dn, input logic up, input int cycles);
      oct_down = dn;
      oct_up   = up;
      repeat (cycles) tick();
   endtask

   initial begin
      int pat, len;
      nrst     = 1'b0;
      oct_down = 1'b0;
      oct_up   = 1'b0;
      applyStimulus(0, 0, 3);
      checkOutput("rst.sel0", 32'(sel0), 32'd0);
      checkOutput("rst.oh0", 32'(oh0), 32'b001);
      checkOutput("rst.sel3", 32'(sel3), 32'd3);
      nrst = 1'b1;
      applyStimulus(0, 0, 5);

      for (int p = 0; p < 4; p++) begin
         applyStimulus(1, 0, 3);
         applyStimulus(0, 0, 6);
      end
      checkOutput("wrap4.sel0", 32'(sel0), 32'd1);
      applyStimulus(1, 0, 3);
      applyStimulus(0, 0, 6);
      checkOutput("sat5.sel1", 32'(sel1), 32'd3);
      checkOutput("sat5.max1", 32'(mx1), 32'd1);
      applyStimulus(0, 1, 3);
      applyStimulus(0, 0, 6);
      checkOutput("satUp.sel1", 32'(sel1), 32'd2);

      applyStimulus(1, 0, 40);
      applyStimulus(0, 0, 15);
      checkOutput("repeat.sel2", 32'(sel2), 32'd0);

      applyStimulus(1, 1, 30);
      applyStimulus(1, 0, 10);
      applyStimulus(0, 0, 6);
      applyStimulus(1, 0, 3);
      applyStimulus(0, 0, 6);

      applyStimulus(1, 0, 8);
      nrst = 1'b0;
      applyStimulus(1, 0, 2);
      nrst = 1'b1;
      applyStimulus(1, 0, 30);
      checkOutput("rstHold.sel2", 32'(sel2), 32'd0);
      checkOutput("rstHold.sel3", 32'(sel3), 32'd3);
      applyStimulus(0, 0, 6);
      applyStimulus(1, 0, 3);
      applyStimulus(0, 0, 6);
      checkOutput("repress.sel2", 32'(sel2), 32'd1);
      checkOutput("repress.sel3", 32'(sel3), 32'd4);

      for (int seg = 0; seg < 150; seg++) begin
         if ($urandom_range(0, 39) == 0) begin
            nrst = 1'b0;
            applyStimulus(oct_down, oct_up, 2);
            nrst = 1'b1;
         end
         pat = $urandom_range(0, 9);
         len = $urandom_range(1, 25);
         if (pat < 4)      applyStimulus(0, 0, len);
         else if (pat < 6) applyStimulus(1, 0, len);
         else if (pat < 8) applyStimulus(0, 1, len);
         else              applyStimulus(1, 1, len);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
      $finish;
   end

endmodule
